alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one 8-bit combinational alu (add/sub/and/or/xor) between NUM_REQ requesters.
//  Round-robin arbiter; registers operands into a single instantiated alu and returns the
//  registered result with the requester ID over a valid/ready response channel.
//  Sits between multiple command sources and the shared ALU datapath.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal 2..8
//  ID_W     1  width of rsp_id; 2**ID_W >= NUM_REQ (elaboration error otherwise)
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          asynchronous active-low reset
//  req_valid   in   NUM_REQ    per-requester command valid
//  req_ready   out  NUM_REQ    per-requester accept, one-hot or zero
//  req_a       in   8*NUM_REQ  operand A, requester i at [8*i+7:8*i]
//  req_b       in   8*NUM_REQ  operand B, same packing
//  req_op      in   3*NUM_REQ  opcode, requester i at [3*i+2:3*i]
//  rsp_valid   out  1          response valid
//  rsp_ready   in   1          response accept
//  rsp_result  out  8          ALU result
//  rsp_id      out  ID_W       index of requester that issued the command
//  busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready=0; rsp_valid=0; rsp_result=0; rsp_id=0;
//   busy=0; operand regs=0; rr pointer last_grant=NUM_REQ-1 (requester 0 has top priority).
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if any req_valid, pick first valid index scanning last_grant+1, +2, ... modulo NUM_REQ.
//   req_ready[g]=1 combinationally in that same cycle; on the edge latch a/b/op/g,
//   last_grant<=g, go EXEC. No valid: stay IDLE, req_ready=0.
//  EXEC (1 cycle): alu driven from latched regs; on the edge rsp_result<=alu result,
//   rsp_id<=g, rsp_valid<=1, go RESP.
//  RESP: rsp_valid, rsp_result, rsp_id held stable until rsp_valid&&rsp_ready; on that edge
//   rsp_valid<=0, go IDLE. req_ready=0 in EXEC and RESP.
//  Latency: accept edge to rsp_valid = 2 cycles; max throughput 1 op per 3 cycles.
//  Ops: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b, 101-111 -> 8'd0.
//   All results 8 bits; add/sub wrap modulo 256, carry/borrow discarded.
//  A requester dropping req_valid without handshake is not latched. The rr pointer only moves
//   on grant. Requesters with req_valid low are skipped.
//  Simultaneous requests: exactly one granted; the other stays pending and is served next
//   round. Requester data outside its handshake cycle is ignored.
//  Reset mid-operation: pending command and response discarded, all outputs return to reset values.
// CONFIGURATION
//  ALU_ILLEGAL_OP_ERR_EN defined: extra output port rsp_err (1 bit, reset 0), registered with
//   rsp_result. rsp_err=1 iff latched op is 101..111; result still 8'd0.
//  Not defined: port rsp_err absent; illegal ops silently return 8'd0.
// TESTING
//  Reset: rst_n=0 -> rsp_valid=0, req_ready=0, busy=0, rsp_result=0.
//  Single command: req0 a=10 b=3 op=000 -> req_ready[0] same cycle; rsp_valid 2 cycles later,
//   rsp_result=13, rsp_id=0. op=001 -> result 7.
//  Wrap: a=8'hFF b=8'h02 op=000 -> 8'h01; a=3 b=10 op=001 -> 8'hF9.
//  Fairness: req0 and req1 held valid continuously after reset -> grant order 0,1,0,1...,
//   each rsp_id matching.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/result/id stable, no req_ready pulses;
//   one cycle after the handshake, state IDLE and next request accepted.
//  Illegal op 110 -> result 0; with ALU_ILLEGAL_OP_ERR_EN defined, rsp_err=1.
//  Reset in EXEC or RESP -> immediate IDLE, rsp_valid=0, and rsp_id 0 on the first
//   post-reset grant.

Source files
------------

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_arbiter
// Purpose  : Round-robin arbiter sharing one 8-bit combinational ALU
//            (add/sub/and/or/xor) between NUM_REQ command sources. The granted
//            command's operands are registered, executed for one cycle, and the
//            registered result is returned with the requester index over a
//            valid/ready response channel.
// Ports    : clk, rst_n (async, active low)
//            req_valid/req_ready  per-requester command handshake
//            req_a/req_b/req_op   packed per-requester operands/opcodes
//            rsp_valid/rsp_ready  response handshake
//            rsp_result, rsp_id   ALU result and issuing requester index
//            busy                 high whenever the FSM is not idle
//            rsp_err              only with ALU_ILLEGAL_OP_ERR_EN defined:
//                                 flags opcodes 101..111
// Config   : `define ALU_ILLEGAL_OP_ERR_EN to add the rsp_err output.
// Revision : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
// Shared combinational ALU. Undefined opcodes produce zero.
// ---------------------------------------------------------------------------
module alu_req_arbiter_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] result
);
  always_comb begin
    result = 8'd0;
    case (op)
      3'b000:  result = a + b;   // wraps modulo 256
      3'b001:  result = a - b;   // wraps modulo 256
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      default: result = 8'd0;
    endcase
  end
endmodule

module alu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_result,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef ALU_ILLEGAL_OP_ERR_EN
  ,
  output logic                 rsp_err
`endif
);

  generate
    if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((1 << ID_W) < NUM_REQ)) begin : g_bad_param
      $error("alu_req_arbiter: NUM_REQ must be 2..8 and 2**ID_W >= NUM_REQ");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [7:0]        r_a;
  logic [7:0]        r_b;
  logic [2:0]        r_op;
  logic [ID_W-1:0]   r_last;     // last granted requester; doubles as the in-flight ID

  logic              w_gnt_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [7:0]        w_sel_a;
  logic [7:0]        w_sel_b;
  logic [2:0]        w_sel_op;
  logic [7:0]        w_alu_result;

  // Round-robin pick: first pass covers indices above the last grant, second
  // pass wraps around to 0..last. The first hit wins, so the requester right
  // after the last grant has the highest priority.
  always_comb begin
    w_gnt_found  = 1'b0;
    w_gnt_idx    = '0;
    w_gnt_onehot = '0;
    w_sel_a      = 8'd0;
    w_sel_b      = 8'd0;
    w_sel_op     = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_found && req_valid[i] && (i > int'(r_last))) begin
        w_gnt_found     = 1'b1;
        w_gnt_idx       = ID_W'(i);
        w_gnt_onehot[i] = 1'b1;
        w_sel_a         = req_a[8*i +: 8];
        w_sel_b         = req_b[8*i +: 8];
        w_sel_op        = req_op[3*i +: 3];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_found && req_valid[i] && (i <= int'(r_last))) begin
        w_gnt_found     = 1'b1;
        w_gnt_idx       = ID_W'(i);
        w_gnt_onehot[i] = 1'b1;
        w_sel_a         = req_a[8*i +: 8];
        w_sel_b         = req_b[8*i +: 8];
        w_sel_op        = req_op[3*i +: 3];
      end
    end
  end

  // Accept is combinational in IDLE; held low while reset is asserted so no
  // requester sees a handshake that the FSM cannot honour.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == IDLE)) begin
      req_ready = w_gnt_onehot;
    end
  end

  assign busy = (r_state != IDLE);

  alu_req_arbiter_alu u_alu (
    .a      (r_a),
    .b      (r_b),
    .op     (r_op),
    .result (w_alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= 8'd0;
      r_b        <= 8'd0;
      r_op       <= 3'd0;
      r_last     <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_id     <= '0;
`ifdef ALU_ILLEGAL_OP_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_found) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_last  <= w_gnt_idx;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= w_alu_result;
          rsp_id     <= r_last;
          rsp_valid  <= 1'b1;
`ifdef ALU_ILLEGAL_OP_ERR_EN
          rsp_err    <= (r_op > 3'b100);
`endif
          r_state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_arbiter
// Purpose  : Directed self-checking bench for alu_req_arbiter (NUM_REQ=2).
//            Inputs are driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic [0:0]  rsp_id;
  logic        busy;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic        rsp_err;
`endif

  int n_tests;
  int n_fail;

  alu_req_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef ALU_ILLEGAL_OP_ERR_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_lane(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
    req_a[8*idx +: 8]  = a;
    req_b[8*idx +: 8]  = b;
    req_op[3*idx +: 3] = op;
  endtask

  // Bounded wait for rsp_valid, sampled on falling edges.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 2'b00;
    req_a     = 16'h0;
    req_b     = 16'h0;
    req_op    = 6'h0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (rsp_result !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=00", rsp_result); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table of single commands: {requester, a, b, op, expected result}.
  task automatic test_single_cmd();
    int          t_idx [10] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0};
    logic [7:0]  t_a   [10] = '{8'd10, 8'd10, 8'hFF, 8'd3, 8'hF0, 8'hF0, 8'hF0, 8'd5, 8'd5, 8'd5};
    logic [7:0]  t_b   [10] = '{8'd3,  8'd3,  8'h02, 8'd10, 8'h3C, 8'h3C, 8'h3C, 8'd6, 8'd6, 8'd6};
    logic [2:0]  t_op  [10] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                                3'b110, 3'b101, 3'b111};
    logic [7:0]  t_exp [10] = '{8'd13, 8'd7, 8'h01, 8'hF9, 8'h30, 8'hFC, 8'hCC, 8'h00, 8'h00, 8'h00};
    logic [1:0]  exp_rdy;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_lane(t_idx[k], t_a[k], t_b[k], t_op[k]);
      req_valid          = 2'b00;
      req_valid[t_idx[k]] = 1'b1;
      exp_rdy            = 2'b00;
      exp_rdy[t_idx[k]]  = 1'b1;
      #1;
      n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL single_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
      @(negedge clk);
      // Scribble over the lane: data outside the handshake must be ignored.
      req_valid = 2'b00;
      set_lane(t_idx[k], 8'hAA, 8'h55, 3'b011);
      n_tests++; if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL single_exec[%0d] got valid,busy=%b exp=01", k, {rsp_valid, busy}); end
      @(negedge clk);
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency[%0d] got=%b exp=1", k, rsp_valid); end
      n_tests++; if (rsp_result !== t_exp[k]) begin n_fail++; $display("FAIL single_result[%0d] got=%h exp=%h", k, rsp_result, t_exp[k]); end
      n_tests++; if (rsp_id !== 1'(t_idx[k])) begin n_fail++; $display("FAIL single_id[%0d] got=%0d exp=%0d", k, rsp_id, t_idx[k]); end
`ifdef ALU_ILLEGAL_OP_ERR_EN
      n_tests++; if (rsp_err !== (t_op[k] > 3'b100)) begin n_fail++; $display("FAIL single_err[%0d] got=%b exp=%b", k, rsp_err, (t_op[k] > 3'b100)); end
`endif
      @(negedge clk);
      n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_done[%0d] got valid,busy=%b exp=00", k, {rsp_valid, busy}); end
    end
  endtask

  task automatic test_fairness();
    bit         ok;
    logic [7:0] exp_res;
    apply_reset();
    set_lane(0, 8'd20, 8'd5, 3'b001);   // 15
    set_lane(1, 8'd20, 8'd5, 3'b011);   // 21
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(ok);
      exp_res = (k % 2 == 0) ? 8'd15 : 8'd21;
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fair_timeout[%0d] got=%b exp=1", k, ok); end
      n_tests++; if (rsp_id !== 1'(k % 2)) begin n_fail++; $display("FAIL fair_id[%0d] got=%0d exp=%0d", k, rsp_id, k % 2); end
      n_tests++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL fair_result[%0d] got=%h exp=%h", k, rsp_result, exp_res); end
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_lane(1, 8'h55, 8'h0F, 3'b100);  // 5A
    req_valid = 2'b10;
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_accept got=%b exp=10", req_ready); end
    @(negedge clk);
    set_lane(0, 8'd7, 8'd1, 3'b000);    // 8
    req_valid = 2'b01;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, rsp_valid); end
      n_tests++; if (rsp_result !== 8'h5A) begin n_fail++; $display("FAIL bp_result[%0d] got=%h exp=5a", k, rsp_result); end
      n_tests++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_id[%0d] got=%0d exp=1", k, rsp_id); end
      n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=00", k, req_ready); end
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", busy); end
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_next_accept got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_next_timeout got=%b exp=1", ok); end
    n_tests++; if (rsp_result !== 8'd8) begin n_fail++; $display("FAIL bp_next_result got=%h exp=08", rsp_result); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_next_id got=%0d exp=0", rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    // Reset while in EXEC.
    @(negedge clk);
    set_lane(1, 8'd1, 8'd1, 3'b000);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b0;
    #1;
    n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_exec got valid,busy=%b exp=00", {rsp_valid, busy}); end
    set_lane(0, 8'd9, 8'd4, 3'b001);    // 5
    req_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_hold_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    wait_rsp(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_rsp_timeout got=%b exp=1", ok); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_id got=%0d exp=0", rsp_id); end
    n_tests++; if (rsp_result !== 8'd5) begin n_fail++; $display("FAIL rst_rsp_result got=%h exp=05", rsp_result); end
    // Reset while in RESP.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_resp got valid,busy=%b exp=00", {rsp_valid, busy}); end
    n_tests++; if (rsp_result !== 8'd0) begin n_fail++; $display("FAIL rst_resp_result got=%h exp=00", rsp_result); end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_cmd();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
